// File: rtl/in_line_controller.sv
// Line buffer and 5x5 window generator: stores a raster pixel stream in a circular
// row buffer and presents every unpadded window over a valid/ready handshake.
module in_line_controller #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int NBUF   = 6,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_start,
    output logic                     o_done,
    input  logic                     pixel_in_valid,
    input  logic [DATA_W-1:0]        pixel_in,
    output logic                     o_conv_valid,
    input  logic                     i_conv_ready,
    output logic                     o_conv_row_start,
    output logic                     o_conv_row_end,
    output logic signed [DATA_W-1:0] window_0_0, window_0_1, window_0_2, window_0_3, window_0_4,
    output logic signed [DATA_W-1:0] window_1_0, window_1_1, window_1_2, window_1_3, window_1_4,
    output logic signed [DATA_W-1:0] window_2_0, window_2_1, window_2_2, window_2_3, window_2_4,
    output logic signed [DATA_W-1:0] window_3_0, window_3_1, window_3_2, window_3_3, window_3_4,
    output logic signed [DATA_W-1:0] window_4_0, window_4_1, window_4_2, window_4_3, window_4_4,
    output logic [2:0]               o_read_base_ptr,
    output logic [2:0]               o_write_ptr,
    output logic [3:0]               o_current_state,
    output logic [4:0]               o_window_col,
    output logic [4:0]               o_output_row_cnt
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_INIT = 4'd1;
    localparam logic [3:0] S_CONV_ROW  = 4'd2;
    localparam logic [3:0] S_ROLL      = 4'd3;
    localparam logic [3:0] S_FINISH    = 4'd4;

    localparam logic [4:0] LAST_WCOL  = 5'(IMG_W - 1);
    localparam logic [4:0] LAST_COL   = 5'(OUT_W - 1);
    localparam logic [4:0] LAST_ROW   = 5'(OUT_H - 1);
    localparam logic [2:0] LAST_SLOT  = 3'(NBUF - 1);
    localparam logic [5:0] ROWS_LOAD  = 6'(K);
    localparam logic [5:0] ROWS_ALL   = 6'(IMG_H);
    localparam logic [5:0] ROWS_AHEAD = 6'(NBUF);

    logic [DATA_W-1:0] line_buf [NBUF][IMG_W];

    logic [3:0]        state_q, state_d;
    logic [4:0]        write_col_q, write_col_d;
    logic [2:0]        write_ptr_q, write_ptr_d;
    logic [5:0]        rows_written_q, rows_written_d;
    logic [2:0]        read_base_ptr_q, read_base_ptr_d;
    logic [4:0]        row_cnt_q, row_cnt_d;
    logic [4:0]        col_q, col_d;
    logic              valid_q, valid_d;
    logic              row_start_q, row_start_d;
    logic              row_end_q, row_end_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] win_q [K][K];
    logic [DATA_W-1:0] win_d [K][K];

    logic       wr_en;
    logic       start_frame;
    logic       load_win;
    logic [4:0] load_col;

    function automatic logic [2:0] slot_of(input logic [2:0] base, input int offset);
        logic [3:0] sum;
        sum = 4'(base) + 4'(offset);
        return (sum >= 4'(NBUF)) ? 3'(sum - 4'(NBUF)) : sum[2:0];
    endfunction

    always_comb begin
        // NOTE: every *_d defaults to its *_q first so no path infers a latch.
        state_d         = state_q;
        write_col_d     = write_col_q;
        write_ptr_d     = write_ptr_q;
        rows_written_d  = rows_written_q;
        read_base_ptr_d = read_base_ptr_q;
        row_cnt_d       = row_cnt_q;
        col_d           = col_q;
        valid_d         = valid_q;
        row_start_d     = row_start_q;
        row_end_d       = row_end_q;
        win_d           = win_q;
        wr_en           = 1'b0;
        load_win        = 1'b0;
        load_col        = col_q;
        start_frame     = ((state_q == S_IDLE) || (state_q == S_FINISH)) && i_start;

        // Write side: free-running once a frame is active, rows beyond the image are dropped.
        if (start_frame) begin
            write_col_d    = '0;
            write_ptr_d    = '0;
            rows_written_d = '0;
        end else if ((state_q != S_IDLE) && pixel_in_valid && (rows_written_q < ROWS_ALL)) begin
            wr_en = 1'b1;
            if (write_col_q == LAST_WCOL) begin
                write_col_d    = '0;
                write_ptr_d    = (write_ptr_q == LAST_SLOT) ? '0 : write_ptr_q + 3'd1;
                rows_written_d = rows_written_q + 6'd1;
            end else begin
                write_col_d = write_col_q + 5'd1;
            end
        end

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (i_start) begin
                    state_d         = S_LOAD_INIT;
                    read_base_ptr_d = '0;
                    row_cnt_d       = '0;
                    col_d           = '0;
                end
            end
            S_LOAD_INIT: begin
                if (rows_written_q >= ROWS_LOAD) begin
                    state_d = S_CONV_ROW;
                    col_d   = '0;
                end
            end
            S_CONV_ROW: begin
                if (!valid_q) begin
                    load_win = 1'b1;
                end else if (i_conv_ready) begin
                    if (col_q == LAST_COL) begin
                        valid_d     = 1'b0;
                        row_start_d = 1'b0;
                        row_end_d   = 1'b0;
                        state_d     = S_ROLL;
                    end else begin
                        col_d    = col_q + 5'd1;
                        load_win = 1'b1;
                        load_col = col_q + 5'd1;
                    end
                end
            end
            S_ROLL: begin
                if (row_cnt_q == LAST_ROW) begin
                    state_d = S_FINISH;
                end else if (rows_written_q >= 6'(row_cnt_q) + ROWS_AHEAD) begin
                    read_base_ptr_d = (read_base_ptr_q == LAST_SLOT) ? '0 : read_base_ptr_q + 3'd1;
                    row_cnt_d       = row_cnt_q + 5'd1;
                    col_d           = '0;
                    state_d         = S_CONV_ROW;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Window, valid and flags are loaded together so they always describe one window.
        if (load_win) begin
            valid_d     = 1'b1;
            row_start_d = (load_col == '0);
            row_end_d   = (load_col == LAST_COL);
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_d[i][j] = line_buf[slot_of(read_base_ptr_q, i)][load_col + 5'(j)];
                end
            end
        end

        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset_n) begin
            state_q         <= S_IDLE;
            write_col_q     <= '0;
            write_ptr_q     <= '0;
            rows_written_q  <= '0;
            read_base_ptr_q <= '0;
            row_cnt_q       <= '0;
            col_q           <= '0;
            valid_q         <= 1'b0;
            row_start_q     <= 1'b0;
            row_end_q       <= 1'b0;
            done_q          <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            state_q         <= state_d;
            write_col_q     <= write_col_d;
            write_ptr_q     <= write_ptr_d;
            rows_written_q  <= rows_written_d;
            read_base_ptr_q <= read_base_ptr_d;
            row_cnt_q       <= row_cnt_d;
            col_q           <= col_d;
            valid_q         <= valid_d;
            row_start_q     <= row_start_d;
            row_end_q       <= row_end_d;
            done_q          <= done_d;
            win_q           <= win_d;
        end
    end

    // NOTE: the line buffer has no reset; every slot is written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[write_ptr_q][write_col_q] <= pixel_in;
        end
    end

    assign o_done           = done_q;
    assign o_conv_valid     = valid_q;
    assign o_conv_row_start = row_start_q;
    assign o_conv_row_end   = row_end_q;
    assign o_read_base_ptr  = read_base_ptr_q;
    assign o_write_ptr      = write_ptr_q;
    assign o_current_state  = state_q;
    assign o_window_col     = col_q;
    assign o_output_row_cnt = row_cnt_q;

    assign window_0_0 = win_q[0][0];
    assign window_0_1 = win_q[0][1];
    assign window_0_2 = win_q[0][2];
    assign window_0_3 = win_q[0][3];
    assign window_0_4 = win_q[0][4];
    assign window_1_0 = win_q[1][0];
    assign window_1_1 = win_q[1][1];
    assign window_1_2 = win_q[1][2];
    assign window_1_3 = win_q[1][3];
    assign window_1_4 = win_q[1][4];
    assign window_2_0 = win_q[2][0];
    assign window_2_1 = win_q[2][1];
    assign window_2_2 = win_q[2][2];
    assign window_2_3 = win_q[2][3];
    assign window_2_4 = win_q[2][4];
    assign window_3_0 = win_q[3][0];
    assign window_3_1 = win_q[3][1];
    assign window_3_2 = win_q[3][2];
    assign window_3_3 = win_q[3][3];
    assign window_3_4 = win_q[3][4];
    assign window_4_0 = win_q[4][0];
    assign window_4_1 = win_q[4][1];
    assign window_4_2 = win_q[4][2];
    assign window_4_3 = win_q[4][3];
    assign window_4_4 = win_q[4][4];

endmodule

// File: tb/tb_in_line_controller.sv
// Self-checking bench for in_line_controller: spot-check table, state trace,
// backpressure holds, mid-frame reset and randomized frames against an image model.
module tb_in_line_controller;

    localparam int W     = 32;
    localparam int NPIX  = 1024;
    localparam int OW    = 28;
    localparam int NWIN  = 784;
    localparam int NBUF  = 6;
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic       pixel_in_valid = 1'b0;
    logic [7:0] pixel_in = '0;
    logic       i_conv_ready = 1'b0;
    logic       o_done, o_conv_valid, o_conv_row_start, o_conv_row_end;
    logic [2:0] o_read_base_ptr, o_write_ptr;
    logic [3:0] o_current_state;
    logic [4:0] o_window_col, o_output_row_cnt;
    wire signed [7:0] win [5][5];

    logic [7:0]  img [NPIX];
    logic [22:0] cap [NWIN];
    logic [199:0] cap_win0;
    int          trace_q [$];
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        int         n;
        logic [7:0] centre;
        logic       rs;
        logic       re;
        logic [4:0] row;
        logic [4:0] col;
        logic [2:0] rbp;
    } spot_t;

    spot_t      spots [7];
    logic [7:0] first_rows [25];

    always #5 clk = ~clk;

    in_line_controller dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_done(o_done),
        .pixel_in_valid(pixel_in_valid), .pixel_in(pixel_in),
        .o_conv_valid(o_conv_valid), .i_conv_ready(i_conv_ready),
        .o_conv_row_start(o_conv_row_start), .o_conv_row_end(o_conv_row_end),
        .window_0_0(win[0][0]), .window_0_1(win[0][1]), .window_0_2(win[0][2]), .window_0_3(win[0][3]), .window_0_4(win[0][4]),
        .window_1_0(win[1][0]), .window_1_1(win[1][1]), .window_1_2(win[1][2]), .window_1_3(win[1][3]), .window_1_4(win[1][4]),
        .window_2_0(win[2][0]), .window_2_1(win[2][1]), .window_2_2(win[2][2]), .window_2_3(win[2][3]), .window_2_4(win[2][4]),
        .window_3_0(win[3][0]), .window_3_1(win[3][1]), .window_3_2(win[3][2]), .window_3_3(win[3][3]), .window_3_4(win[3][4]),
        .window_4_0(win[4][0]), .window_4_1(win[4][1]), .window_4_2(win[4][2]), .window_4_3(win[4][3]), .window_4_4(win[4][4]),
        .o_read_base_ptr(o_read_base_ptr), .o_write_ptr(o_write_ptr),
        .o_current_state(o_current_state), .o_window_col(o_window_col),
        .o_output_row_cnt(o_output_row_cnt)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [199:0] dut_win();
        logic [199:0] v = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                v[(i*5+j)*8 +: 8] = win[i][j];
        return v;
    endfunction

    // Reference: window (r,c) is the 5x5 image patch with top-left at (r,c).
    function automatic logic [199:0] model_win(input int r, input int c);
        logic [199:0] v = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                v[(i*5+j)*8 +: 8] = img[(r+i)*W + c + j];
        return v;
    endfunction

    function automatic logic [214:0] win_status();
        return {o_output_row_cnt, o_window_col, o_read_base_ptr, o_conv_row_start, o_conv_row_end, dut_win()};
    endfunction

    function automatic logic [214:0] exp_status(input int r, input int c);
        return {5'(r), 5'(c), 3'(r % NBUF), c == 0, c == OW-1, model_win(r, c)};
    endfunction

    function automatic logic [212:0] hold_view();
        return {o_conv_valid, o_conv_row_start, o_conv_row_end, o_output_row_cnt, o_window_col, dut_win()};
    endfunction

    function automatic logic [223:0] all_outs();
        return {o_done, o_conv_valid, o_conv_row_start, o_conv_row_end, o_read_base_ptr,
                o_write_ptr, o_current_state, o_window_col, o_output_row_cnt, dut_win()};
    endfunction

    // mode 0: contiguous pixels, ready high except an optional 3-cycle stall.
    // mode 1: random pixel gaps and random ready. The source never starts image
    // row R before output row R-6 has been fully accepted.
    task automatic run_frame(input int mode, input int delay, input int stall_at, input int abort_row,
                             input int extra_px, input bit capture, output int n_acc);
        int   pix = 0;
        int   acc = 0;
        int   cyc = 0;
        int   stall_left = 0;
        int   row;
        bit   stall_used = 1'b0;
        bit   hold_pending = 1'b0;
        bit   allow;
        logic [255:0] held = '0;
        logic [3:0]   last_state;
        trace_q.delete();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_clears", {o_done, o_read_base_ptr, o_write_ptr, o_current_state, o_output_row_cnt, o_window_col},
              {1'b0, 3'd0, 3'd0, 4'd1, 5'd0, 5'd0});
        last_state = o_current_state;
        trace_q.push_back(int'(last_state));
        forever begin
            if (hold_pending)
                check("hold", hold_view(), held);
            if (o_done && pix >= NPIX + extra_px)
                break;
            if (cyc >= LIMIT) begin
                check("frame_timeout_done", {31'd0, o_done}, 1);
                break;
            end
            if (abort_row >= 0 && o_conv_valid && o_output_row_cnt == 5'(abort_row) && o_window_col == 5'd5) begin
                reset_n = 1'b0;
                pixel_in_valid = 1'b0;
                i_conv_ready = 1'b0;
                @(negedge clk);
                check("reset_mid_frame", all_outs(), '0);
                reset_n = 1'b1;
                break;
            end
            if (mode == 0) begin
                if (stall_at >= 0 && !stall_used && acc == stall_at && o_conv_valid) begin
                    stall_used = 1'b1;
                    stall_left = 3;
                end
                i_conv_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else begin
                i_conv_ready = ($urandom_range(3) != 0);
            end
            if (o_conv_valid && i_conv_ready) begin
                if (acc < NWIN) begin
                    check($sformatf("window %0d", acc), win_status(), exp_status(acc / OW, acc % OW));
                    if (capture) begin
                        cap[acc] = {win[2][2], o_conv_row_start, o_conv_row_end, o_output_row_cnt, o_window_col, o_read_base_ptr};
                        if (acc == 0) cap_win0 = dut_win();
                    end
                end else begin
                    check("window_overrun", acc, NWIN - 1);
                end
                acc++;
            end
            hold_pending = o_conv_valid && !i_conv_ready;
            held = hold_view();
            row = pix / W;
            allow = (cyc >= delay) && (pix < NPIX + extra_px) && (row < NBUF || acc >= (row - (NBUF-1)) * OW);
            if (mode != 0 && $urandom_range(3) == 0) allow = 1'b0;
            pixel_in_valid = allow;
            if (pix < NPIX) pixel_in = img[pix];
            else            pixel_in = 8'hFF;
            if (allow) pix++;
            @(negedge clk);
            cyc++;
            if (o_current_state != last_state) begin
                last_state = o_current_state;
                trace_q.push_back(int'(last_state));
            end
        end
        pixel_in_valid = 1'b0;
        i_conv_ready = 1'b1;
        n_acc = acc;
    endtask

    task automatic spec_image();
        for (int k = 0; k < NPIX; k++) img[k] = 8'(k % 256);
        img[0] = 8'hAA;
        img[31] = 8'hBB;
        img[992] = 8'hCC;
        img[1023] = 8'hDD;
        for (int i = 0; i < 32; i++) img[33*i] = 8'hEE;
    endtask

    task automatic random_image();
        for (int k = 0; k < NPIX; k++) img[k] = 8'($urandom);
    endtask

    initial begin
        int n;
        int bad;
        int exp_trace [$];
        logic [199:0] first_exp;

        spots[0] = '{0,   8'hEE, 1'b1, 1'b0, 5'd0,  5'd0,  3'd0};
        spots[1] = '{27,  8'h5D, 1'b0, 1'b1, 5'd0,  5'd27, 3'd0};
        spots[2] = '{28,  8'h62, 1'b1, 1'b0, 5'd1,  5'd0,  3'd1};
        spots[3] = '{55,  8'h7D, 1'b0, 1'b1, 5'd1,  5'd27, 3'd1};
        spots[4] = '{400, 8'h0A, 1'b0, 1'b0, 5'd14, 5'd8,  3'd2};
        spots[5] = '{756, 8'hA2, 1'b1, 1'b0, 5'd27, 5'd0,  3'd3};
        spots[6] = '{783, 8'hEE, 1'b0, 1'b1, 5'd27, 5'd27, 3'd3};
        first_rows = '{8'hEE, 8'h01, 8'h02, 8'h03, 8'h04,
                       8'h20, 8'hEE, 8'h22, 8'h23, 8'h24,
                       8'h40, 8'h41, 8'hEE, 8'h43, 8'h44,
                       8'h60, 8'h61, 8'h62, 8'hEE, 8'h64,
                       8'h80, 8'h81, 8'h82, 8'h83, 8'hEE};
        for (int k = 0; k < 25; k++) first_exp[k*8 +: 8] = first_rows[k];
        for (int k = 0; k < NWIN; k++) cap[k] = 'x;
        cap_win0 = 'x;

        repeat (3) @(negedge clk);
        check("reset_state", all_outs(), '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Frame A: test image, contiguous pixels, ready held high, 40 surplus pixels.
        spec_image();
        run_frame(0, 9, -1, -1, 40, 1'b1, n);
        check("count_A", n, NWIN);
        check("finish_A", {o_done, o_conv_valid, o_current_state, o_write_ptr}, {1'b1, 1'b0, 4'd4, 3'd2});
        exp_trace.delete();
        exp_trace.push_back(1);
        for (int r = 0; r < 28; r++) begin
            exp_trace.push_back(2);
            exp_trace.push_back(3);
        end
        exp_trace.push_back(4);
        check("trace_len", trace_q.size(), exp_trace.size());
        bad = 0;
        for (int i = 0; i < trace_q.size() && i < exp_trace.size(); i++)
            if (trace_q[i] != exp_trace[i]) bad++;
        check("trace_seq", bad, 0);
        for (int s = 0; s < 7; s++)
            check($sformatf("spot %0d", spots[s].n), cap[spots[s].n],
                  {spots[s].centre, spots[s].rs, spots[s].re, spots[s].row, spots[s].col, spots[s].rbp});
        check("first_window", cap_win0, first_exp);

        // Frame B: restart from FINISH, 3-cycle ready stall mid-row 3.
        run_frame(0, 2, 100, -1, 0, 1'b0, n);
        check("count_B", n, NWIN);
        check("finish_B", {o_done, o_conv_valid, o_current_state}, {1'b1, 1'b0, 4'd4});

        // Frame C: random image and traffic, reset asserted mid output row 10.
        random_image();
        run_frame(1, 0, -1, 10, 0, 1'b0, n);
        check("count_before_reset", n, 10*OW + 5);
        @(negedge clk);
        check("idle_after_reset", {o_current_state, o_done, o_conv_valid}, {4'd0, 1'b0, 1'b0});

        // Frame D: fresh random frame after the reset.
        random_image();
        run_frame(1, 0, -1, -1, 0, 1'b0, n);
        check("count_D", n, NWIN);
        check("finish_D", {o_done, o_conv_valid, o_current_state}, {1'b1, 1'b0, 4'd4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
